// File: rtl/abstract_cmd_encode_pkg.sv
// Shared definitions for the debug-module abstract-command engine:
// DM command/error encodings, RISC-V SYSTEM opcode fields, FSM state type,
// and the packed layouts of the command word and of a CSR instruction.
package abstract_cmd_encode_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned STEP_W   = 2;

    // Debug-module encodings
    localparam logic [7:0]  DM__CMDTYPE_ACCESS_REG = 8'd0;
    localparam logic [2:0]  DM__AARSIZE_32         = 3'd2;
    localparam logic [2:0]  DM__CMDERR_NONE        = 3'd0;
    localparam logic [2:0]  DM__CMDERR_BUSY        = 3'd1;
    localparam logic [2:0]  DM__CMDERR_NOTSUP      = 3'd2;
    localparam logic [2:0]  DM__CMDERR_EXCEPTION   = 3'd3;
    localparam logic [2:0]  DM__CMDERR_HALTRESUME  = 3'd4;
    localparam logic [15:0] DM__REGNO_GPR_BASE     = 16'h1000;
    localparam logic [11:0] DM__DSCRATCH0          = 12'h7B2;
    localparam logic [11:0] DM__DSCRATCH1          = 12'h7B3;

    // ISA encodings
    localparam logic [6:0]  ISA__OPCODE_SYSTEM = 7'h73;
    localparam logic [2:0]  ISA__FUNCT3_CSRRW  = 3'b001;
    localparam logic [2:0]  ISA__FUNCT3_CSRRS  = 3'b010;

    typedef logic [STEP_W-1:0] step_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Access Register command word
    typedef struct packed {
        logic [7:0]  cmdtype;
        logic        rsvd23;
        logic [2:0]  aarsize;
        logic        rsvd19;
        logic        postexec;
        logic        transfer;
        logic        write;
        logic [15:0] regno;
    } dm_cmd_t;

    // Operand fields of a SYSTEM I-type CSR instruction
    typedef struct packed {
        logic [11:0] csr;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
    } csr_inst_t;

    function automatic logic [31:0] csr_itype(input csr_inst_t f);
        return {f.csr, f.rs1, f.funct3, f.rd, ISA__OPCODE_SYSTEM};
    endfunction

endpackage

// File: rtl/abstract_cmd_encode_csr_inst_encode.sv
// Combinational CSR instruction encoder.
// Ports:
//   fields  in   csr_inst_t  csr, rs1, funct3, rd operands
//   word_c  out  32          SYSTEM I-type instruction word
module csr_inst_encode
    import abstract_cmd_encode_pkg::*;
(
    input  csr_inst_t   fields,
    output logic [31:0] word_c
);

    assign word_c = csr_itype(fields);

endmodule

// File: rtl/abstract_cmd_encode.sv
// Debug-module abstract-command engine. Accepts an Access Register command,
// expands it into CSR instructions exchanging data through dscratch0, and
// injects them one at a time into the halted core over a valid/ready port.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd   command handshake and 32-bit command word
//   cmderr_clr    clear sticky cmderr (ignored while busy)
//   halted        core is halted
//   inst_valid/inst/inst_ready   instruction injection port
//   exec_done/exec_exc           retire / exception of accepted instruction
//   busy, cmderr, done, postexec_go   status to the DM register file
module abstract_cmd_encode
    import abstract_cmd_encode_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEF,
    parameter int unsigned SCRATCH_GPR = 8,
    parameter logic [11:0] DATA_CSR    = DM__DSCRATCH0,
    parameter logic [11:0] SAVE_CSR    = DM__DSCRATCH1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [31:0]     cmd,
    input  logic            cmderr_clr,
    input  logic            halted,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    input  logic            inst_ready,
    input  logic            exec_done,
    input  logic            exec_exc,
    output logic            busy,
    output logic [2:0]      cmderr,
    output logic            done,
    output logic            postexec_go
);

    localparam logic [4:0] SCR = 5'(SCRATCH_GPR);
    localparam step_t      STEP_LAST_CSR = step_t'(3);
    localparam step_t      STEP_LAST_GPR = step_t'(0);

    dm_cmd_t cmd_s;
    assign cmd_s = cmd;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{cmd_s.rsvd23, cmd_s.rsvd19};

    // Registered state and latched command fields
    state_t      state, state_nxt;
    step_t       step, step_nxt;
    logic        lat_is_csr, lat_is_csr_nxt;
    logic        lat_write, lat_write_nxt;
    logic        lat_postexec, lat_postexec_nxt;
    logic [11:0] lat_regno, lat_regno_nxt;
    logic [2:0]  cmderr_nxt;

    logic            cmd_ready_nxt;
    logic            inst_valid_nxt;
    logic [XLEN-1:0] inst_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic            postexec_go_nxt;

    // Command classification at accept time
    logic regno_is_csr_c;
    logic regno_is_gpr_c;
    logic cmd_ok_c;
    assign regno_is_csr_c = (cmd_s.regno[15:12] == 4'h0);
    assign regno_is_gpr_c = (cmd_s.regno[15:5] == DM__REGNO_GPR_BASE[15:5]);
    assign cmd_ok_c       = (cmd_s.cmdtype == DM__CMDTYPE_ACCESS_REG)
                         && (cmd_s.aarsize == DM__AARSIZE_32)
                         && (regno_is_csr_c || regno_is_gpr_c);

    // Operand selection for the instruction at step_nxt
    csr_inst_t   enc_fields;
    logic [31:0] enc_word_c;

    always_comb begin
        enc_fields = '0;
        if (!lat_is_csr_nxt) begin
            enc_fields.csr = DATA_CSR;
            if (lat_write_nxt) begin
                enc_fields.funct3 = ISA__FUNCT3_CSRRS;
                enc_fields.rd     = lat_regno_nxt[4:0];
            end else begin
                enc_fields.funct3 = ISA__FUNCT3_CSRRW;
                enc_fields.rs1    = lat_regno_nxt[4:0];
            end
        end else begin
            // Even steps move scratch into a CSR, odd steps pull a CSR into scratch
            if (step_nxt[0]) begin
                enc_fields.funct3 = ISA__FUNCT3_CSRRS;
                enc_fields.rd     = SCR;
            end else begin
                enc_fields.funct3 = ISA__FUNCT3_CSRRW;
                enc_fields.rs1    = SCR;
            end
            unique case (step_nxt)
                step_t'(1): enc_fields.csr = lat_write_nxt ? DATA_CSR : lat_regno_nxt;
                step_t'(2): enc_fields.csr = lat_write_nxt ? lat_regno_nxt : DATA_CSR;
                default:    enc_fields.csr = SAVE_CSR;
            endcase
        end
    end

    csr_inst_encode u_enc (
        .fields (enc_fields),
        .word_c (enc_word_c)
    );

    // Next-state, cmderr and registered-output logic
    always_comb begin
        state_nxt        = state;
        step_nxt         = step;
        lat_is_csr_nxt   = lat_is_csr;
        lat_write_nxt    = lat_write;
        lat_postexec_nxt = lat_postexec;
        lat_regno_nxt    = lat_regno;
        cmderr_nxt       = cmderr;

        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    step_nxt         = '0;
                    lat_is_csr_nxt   = regno_is_csr_c;
                    lat_write_nxt    = cmd_s.write;
                    lat_postexec_nxt = cmd_s.postexec;
                    lat_regno_nxt    = cmd_s.regno[11:0];
                    if (cmderr != DM__CMDERR_NONE) begin
                        state_nxt = ST_FINISH;
                    end else if (!halted) begin
                        cmderr_nxt = DM__CMDERR_HALTRESUME;
                        state_nxt  = ST_FINISH;
                    end else if (!cmd_ok_c) begin
                        cmderr_nxt = DM__CMDERR_NOTSUP;
                        state_nxt  = ST_FINISH;
                    end else if (!cmd_s.transfer) begin
                        state_nxt = ST_FINISH;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end else if (cmderr_clr) begin
                    cmderr_nxt = DM__CMDERR_NONE;
                end
            end
            ST_ISSUE: begin
                if (inst_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (exec_exc) begin
                    cmderr_nxt = DM__CMDERR_EXCEPTION;
                    // Scratch GPR has been clobbered; still run the restore step
                    if (lat_is_csr && (step == step_t'(1) || step == step_t'(2))) begin
                        step_nxt  = STEP_LAST_CSR;
                        state_nxt = ST_ISSUE;
                    end else begin
                        state_nxt = ST_FINISH;
                    end
                end else if (exec_done) begin
                    if (step == (lat_is_csr ? STEP_LAST_CSR : STEP_LAST_GPR)) begin
                        state_nxt = ST_FINISH;
                    end else begin
                        step_nxt  = step + step_t'(1);
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // New command while busy: flag only if no other error is pending
        if (state != ST_IDLE && cmd_valid
            && cmderr == DM__CMDERR_NONE && cmderr_nxt == DM__CMDERR_NONE) begin
            cmderr_nxt = DM__CMDERR_BUSY;
        end

        cmd_ready_nxt   = (state_nxt == ST_IDLE);
        inst_valid_nxt  = (state_nxt == ST_ISSUE);
        inst_nxt        = (state_nxt == ST_ISSUE) ? XLEN'(enc_word_c) : '0;
        busy_nxt        = (state_nxt != ST_IDLE);
        done_nxt        = (state_nxt == ST_FINISH);
        postexec_go_nxt = (state_nxt == ST_FINISH) && lat_postexec_nxt
                       && (cmderr_nxt == DM__CMDERR_NONE);
    end

    // State, latched fields and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            step         <= '0;
            lat_is_csr   <= 1'b0;
            lat_write    <= 1'b0;
            lat_postexec <= 1'b0;
            lat_regno    <= '0;
            cmderr       <= DM__CMDERR_NONE;
            cmd_ready    <= 1'b1;
            inst_valid   <= 1'b0;
            inst         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            postexec_go  <= 1'b0;
        end else begin
            state        <= state_nxt;
            step         <= step_nxt;
            lat_is_csr   <= lat_is_csr_nxt;
            lat_write    <= lat_write_nxt;
            lat_postexec <= lat_postexec_nxt;
            lat_regno    <= lat_regno_nxt;
            cmderr       <= cmderr_nxt;
            cmd_ready    <= cmd_ready_nxt;
            inst_valid   <= inst_valid_nxt;
            inst         <= inst_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            postexec_go  <= postexec_go_nxt;
        end
    end

endmodule
